// File: rtl/cpu_seq.sv
// cpu_seq: two-cycle accumulator sequencer (fetch/execute) with handshaked port
// I/O and an external loader that can take the program RAM between instructions.
module cpu_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_ram_addr,
  input  logic [15:0] i_ram_dout,
  output logic [15:0] o_ram_din,
  output logic        o_ram_we,
  input  logic        i_ld_en,
  input  logic        i_ld_we,
  input  logic [7:0]  i_ld_addr,
  input  logic [15:0] i_ld_data,
  output logic        o_ld_gnt,
  output logic [7:0]  o_io_addr,
  output logic        o_io_rd,
  output logic        o_io_wr,
  output logic [7:0]  o_io_dout,
  input  logic [7:0]  i_io_din,
  input  logic        i_io_ack,
  output logic [7:0]  o_acc,
  output logic        o_zf,
  output logic        o_cf,
  output logic [7:0]  o_pc
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_EXEC    = 2'd2,
    ST_IO_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JCC  = 4'b1001;
  localparam logic [3:0] OP_IN   = 4'b1010;
  localparam logic [3:0] OP_OUT  = 4'b1110;

  function automatic logic is_zero(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_nx;
  logic [15:0] r_ir;
  logic [15:0] w_ir_nx;
  logic [7:0]  r_acc;
  logic [7:0]  w_acc_nx;
  logic        r_zf;
  logic        w_zf_nx;
  logic        r_cf;
  logic        w_cf_nx;

  logic [3:0]  w_op;
  logic [7:0]  w_imm;
  logic        w_is_in;
  logic        w_is_out;
  logic        w_cond;
  logic [8:0]  w_sum;
  logic [8:0]  w_diff;

  assign w_op     = r_ir[15:12];
  assign w_imm    = r_ir[7:0];
  assign w_is_in  = (w_op == OP_IN);
  assign w_is_out = (w_op == OP_OUT);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_imm};
  // Bit 8 of the 9-bit difference is the borrow (ACC < operand).
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_imm};

  assign o_io_addr = w_imm;
  assign o_io_dout = r_acc;
  assign o_acc     = r_acc;
  assign o_zf      = r_zf;
  assign o_cf      = r_cf;
  assign o_pc      = r_pc;

  // Conditional-jump predicate selected by IR[11:10]; IR[9:8] are don't-care.
  always_comb begin
    casez (r_ir[11:8])
      4'b00??: w_cond = r_zf;
      4'b01??: w_cond = ~r_zf;
      4'b10??: w_cond = r_cf;
      4'b11??: w_cond = ~r_cf;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-state, datapath update and RAM/port steering for the current state.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_ir_nx    = r_ir;
    w_acc_nx   = r_acc;
    w_zf_nx    = r_zf;
    w_cf_nx    = r_cf;
    o_ram_addr = r_pc;
    o_ram_din  = 16'h0000;
    o_ram_we   = 1'b0;
    o_ld_gnt   = 1'b0;
    o_io_rd    = 1'b0;
    o_io_wr    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (i_ld_en) begin
          w_state_nx = ST_LOAD;
        end else begin
          w_ir_nx    = i_ram_dout;
          w_pc_nx    = r_pc + 8'd1;
          w_state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nx = ST_FETCH;
        case (w_op)
          OP_LOAD: begin
            w_acc_nx = w_imm;
            w_zf_nx  = is_zero(w_imm);
          end
          OP_ADD: begin
            w_acc_nx = w_sum[7:0];
            w_cf_nx  = w_sum[8];
            w_zf_nx  = is_zero(w_sum[7:0]);
          end
          OP_AND: begin
            w_acc_nx = r_acc & w_imm;
            w_cf_nx  = 1'b0;
            w_zf_nx  = is_zero(r_acc & w_imm);
          end
          OP_SUB: begin
            w_acc_nx = w_diff[7:0];
            w_cf_nx  = w_diff[8];
            w_zf_nx  = is_zero(w_diff[7:0]);
          end
          OP_JMP: begin
            w_pc_nx = w_imm;
          end
          OP_JCC: begin
            if (w_cond) begin
              w_pc_nx = w_imm;
            end else begin
              w_pc_nx = r_pc;
            end
          end
          OP_IN: begin
            o_io_rd    = 1'b1;
            w_state_nx = ST_IO_WAIT;
          end
          OP_OUT: begin
            o_io_wr    = 1'b1;
            w_state_nx = ST_IO_WAIT;
          end
          default: begin
            w_state_nx = ST_FETCH;
          end
        endcase
      end
      ST_IO_WAIT: begin
        // Request stays up through the acknowledging cycle and drops in FETCH.
        o_io_rd = w_is_in;
        o_io_wr = w_is_out;
        if (i_io_ack) begin
          w_state_nx = ST_FETCH;
          if (w_is_in) begin
            w_acc_nx = i_io_din;
            w_zf_nx  = is_zero(i_io_din);
          end else begin
            w_acc_nx = r_acc;
          end
        end else begin
          w_state_nx = ST_IO_WAIT;
        end
      end
      ST_LOAD: begin
        o_ld_gnt   = 1'b1;
        o_ram_addr = i_ld_addr;
        o_ram_din  = i_ld_data;
        o_ram_we   = i_ld_we;
        if (i_ld_en) begin
          w_state_nx = ST_LOAD;
        end else begin
          w_pc_nx    = RESET_PC;
          w_state_nx = ST_FETCH;
        end
      end
      default: begin
        w_state_nx = ST_FETCH;
      end
    endcase
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_acc   <= 8'h00;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_ir    <= w_ir_nx;
      r_acc   <= w_acc_nx;
      r_zf    <= w_zf_nx;
      r_cf    <= w_cf_nx;
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_cpu_seq;

  localparam logic [7:0] RPC = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;
  logic        ram_we;
  logic        ld_en;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_gnt;
  logic [7:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        io_ack;
  logic [7:0]  acc;
  logic        zf;
  logic        cf;
  logic [7:0]  pc;

  logic [15:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  logic [7:0]  m_pc;
  logic [7:0]  m_acc;
  logic        m_zf;
  logic        m_cf;
  int          n_chk;
  int          n_err;
  int          io_cycles;

  always #5 clk = ~clk;

  cpu_seq #(.RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_ram_addr(ram_addr), .i_ram_dout(ram_dout), .o_ram_din(ram_din), .o_ram_we(ram_we),
    .i_ld_en(ld_en), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_gnt(ld_gnt),
    .o_io_addr(io_addr), .o_io_rd(io_rd), .o_io_wr(io_wr), .o_io_dout(io_dout),
    .i_io_din(io_din), .i_io_ack(io_ack),
    .o_acc(acc), .o_zf(zf), .o_cf(cf), .o_pc(pc)
  );

  // Program RAM: asynchronous read, written by the DUT loader or the bench backdoor.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [15:0] d);
    rst = 1'b1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_en = 1'b0; ld_we = 1'b0; io_ack = 1'b0;
    tick();
    rst = 1'b0;
    m_pc = RPC; m_acc = 8'h00; m_zf = 1'b0; m_cf = 1'b0;
  endtask

  // Instruction-level semantics for every non-I/O opcode.
  task automatic model_exec(input logic [15:0] ins);
    int a, b, r;
    logic take;
    a = int'(m_acc);
    b = int'(ins[7:0]);
    take = 1'b0;
    case (ins[15:12])
      4'h0: begin r = b; m_acc = r[7:0]; m_zf = (r == 0); end
      4'h4: begin r = a + b; m_cf = (r > 255); r = r % 256; m_acc = r[7:0]; m_zf = (r == 0); end
      4'h1: begin r = a & b; m_cf = 1'b0; m_acc = r[7:0]; m_zf = (r == 0); end
      4'h6: begin m_cf = (a < b); r = (a - b + 256) % 256; m_acc = r[7:0]; m_zf = (r == 0); end
      4'h8: m_pc = ins[7:0];
      4'h9: begin
        case (ins[11:10])
          2'b00: take = m_zf;
          2'b01: take = !m_zf;
          2'b10: take = m_cf;
          default: take = !m_cf;
        endcase
        if (take) m_pc = ins[7:0];
      end
      default: ;
    endcase
  endtask

  // Run one instruction from its FETCH cycle; I/O acked after wait_n idle wait cycles.
  task automatic run_instr(input int wait_n, input logic [7:0] din);
    logic [15:0] ins;
    logic is_in, is_out;
    ld_en = 1'b0; io_ack = 1'b0;
    #2;
    check_val("fetch_addr", 32'(ram_addr), 32'(m_pc));
    check_val("pc", 32'(pc), 32'(m_pc));
    check_val("acc", 32'(acc), 32'(m_acc));
    check_val("zf", 32'(zf), 32'(m_zf));
    check_val("cf", 32'(cf), 32'(m_cf));
    check_val("fetch_io_req", 32'({io_rd, io_wr, ld_gnt, ram_we}), 32'(0));
    ins = mem[m_pc];
    m_pc = m_pc + 8'd1;
    tick();
    is_in  = (ins[15:12] == 4'hA);
    is_out = (ins[15:12] == 4'hE);
    io_ack = 1'($urandom_range(0, 1));
    io_din = 8'($urandom);
    #2;
    check_val("exec_io_rd", 32'(io_rd), 32'(is_in));
    check_val("exec_io_wr", 32'(io_wr), 32'(is_out));
    io_cycles = 0;
    if (is_in || is_out) begin
      io_cycles = 1;
      check_val("exec_io_addr", 32'(io_addr), 32'(ins[7:0]));
      if (is_out) check_val("exec_io_dout", 32'(io_dout), 32'(m_acc));
      for (int k = 0; k <= wait_n; k++) begin
        tick();
        io_ack = (k == wait_n);
        io_din = (k == wait_n) ? din : 8'($urandom);
        #2;
        check_val("wait_io_rd", 32'(io_rd), 32'(is_in));
        check_val("wait_io_wr", 32'(io_wr), 32'(is_out));
        check_val("wait_io_addr", 32'(io_addr), 32'(ins[7:0]));
        if (is_out) check_val("wait_io_dout", 32'(io_dout), 32'(m_acc));
        if (io_rd || io_wr) io_cycles++;
      end
      tick();
      io_ack = 1'b0;
      if (is_in) begin
        m_acc = din;
        m_zf = (din == 8'h00);
      end
    end else begin
      tick();
      model_exec(ins);
    end
  endtask

  logic [3:0] ops [12] = '{4'h0, 4'h4, 4'h1, 4'h6, 4'h8, 4'h9, 4'hA, 4'hE, 4'h0, 4'h4, 4'h6, 4'h3};

  initial begin
    n_chk = 0; n_err = 0; io_cycles = 0;
    rst = 1'b1; ld_en = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
    io_din = 8'h00; io_ack = 1'b0; bd_we = 1'b0; bd_addr = 8'h00; bd_data = 16'h0000;
    for (int i = 0; i < 256; i++) bd_write(8'(i), 16'h3000);

    // Load F0, Add 20: carry out, zero clear.
    bd_write(RPC, 16'h00F0); bd_write(RPC + 8'd1, 16'h4020);
    do_reset();
    check_val("rst_pc", 32'(pc), 32'(RPC));
    check_val("rst_acc", 32'(acc), 32'(0));
    check_val("rst_flags", 32'({zf, cf}), 32'(0));
    check_val("rst_ctl", 32'({io_rd, io_wr, ld_gnt, ram_we}), 32'(0));
    run_instr(0, 8'h00); run_instr(0, 8'h00);
    check_val("add_acc", 32'(acc), 32'(8'h10));
    check_val("add_cf", 32'(cf), 32'(1));
    check_val("add_zf", 32'(zf), 32'(0));
    check_val("add_pc", 32'(pc), 32'(RPC + 8'd2));

    // Sub to zero then JZ taken; same with JNZ falls through.
    bd_write(RPC, 16'h0005); bd_write(RPC + 8'd1, 16'h6005); bd_write(RPC + 8'd2, 16'h9040);
    bd_write(8'h40, 16'h0005); bd_write(8'h41, 16'h6005); bd_write(8'h42, 16'h9440);
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 8'h00);
    check_val("jz_zf", 32'(zf), 32'(1));
    check_val("jz_cf", 32'(cf), 32'(0));
    check_val("jz_pc", 32'(pc), 32'(8'h40));
    for (int i = 0; i < 3; i++) run_instr(0, 8'h00);
    check_val("jnz_pc", 32'(pc), 32'(8'h43));

    // Input port 6 acknowledged on the third wait cycle with data 0.
    bd_write(RPC, 16'h00FF); bd_write(RPC + 8'd1, 16'hA006);
    do_reset();
    run_instr(0, 8'h00); run_instr(2, 8'h00);
    check_val("in_rd_cycles", 32'(io_cycles), 32'(4));
    check_val("in_acc", 32'(acc), 32'(0));
    check_val("in_zf", 32'(zf), 32'(1));
    check_val("in_pc", 32'(pc), 32'(RPC + 8'd2));
    run_instr(0, 8'h00);

    // PC wraps from 0xFF to 0x00.
    bd_write(RPC, 16'h80FF); bd_write(8'hFF, 16'h0011);
    do_reset();
    run_instr(0, 8'h00); run_instr(0, 8'h00);
    check_val("wrap_pc", 32'(pc), 32'(0));
    run_instr(0, 8'h00);

    // Loader request during Output wait is deferred until the next FETCH.
    bd_write(RPC, 16'h0055); bd_write(RPC + 8'd1, 16'hE009);
    do_reset();
    run_instr(0, 8'h00);
    ld_en = 1'b0; io_ack = 1'b0; #2;
    check_val("ld_fetch_addr", 32'(ram_addr), 32'(RPC + 8'd1));
    tick(); #2;
    check_val("out_wr", 32'(io_wr), 32'(1));
    check_val("out_dout", 32'(io_dout), 32'(8'h55));
    tick(); ld_en = 1'b1; #2;
    check_val("ldw_gnt0", 32'(ld_gnt), 32'(0));
    check_val("ldw_wr", 32'(io_wr), 32'(1));
    tick(); io_ack = 1'b1; #2;
    check_val("lda_gnt0", 32'(ld_gnt), 32'(0));
    tick(); io_ack = 1'b0; #2;
    check_val("ldf_gnt0", 32'(ld_gnt), 32'(0));
    check_val("ldf_wr_drop", 32'(io_wr), 32'(0));
    tick(); ld_we = 1'b1; ld_addr = 8'h10; ld_data = 16'h1234; #2;
    check_val("ld_gnt", 32'(ld_gnt), 32'(1));
    check_val("ld_we", 32'(ram_we), 32'(1));
    check_val("ld_addr", 32'(ram_addr), 32'(8'h10));
    check_val("ld_din", 32'(ram_din), 32'(16'h1234));
    tick(); ld_we = 1'b0; #2;
    check_val("ld_we_pulse", 32'(ram_we), 32'(0));
    check_val("ld_mem", 32'(mem[8'h10]), 32'(16'h1234));
    ld_en = 1'b0;
    tick();
    check_val("ld_exit_gnt", 32'(ld_gnt), 32'(0));
    check_val("ld_exit_pc", 32'(pc), 32'(RPC));
    check_val("ld_exit_acc", 32'(acc), 32'(8'h55));
    m_pc = RPC;
    run_instr(0, 8'h00);

    // Reset overrides IO_WAIT and LOAD; ld_en held through reset goes straight to LOAD.
    bd_write(RPC, 16'h0077); bd_write(RPC + 8'd1, 16'hA003);
    do_reset();
    run_instr(0, 8'h00);
    ld_en = 1'b0; io_ack = 1'b0;
    tick(); tick(); #2;
    check_val("rw_io_rd", 32'(io_rd), 32'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("rw_ctl", 32'({io_rd, io_wr, ld_gnt, ram_we}), 32'(0));
    check_val("rw_acc", 32'(acc), 32'(0));
    check_val("rw_pc", 32'(pc), 32'(RPC));
    ld_en = 1'b1; #2;
    check_val("rl_fetch_gnt", 32'(ld_gnt), 32'(0));
    tick(); ld_we = 1'b1; ld_addr = 8'hF0; ld_data = 16'hBEEF; #2;
    check_val("rl_gnt", 32'(ld_gnt), 32'(1));
    check_val("rl_pc", 32'(pc), 32'(RPC));
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("rl_ctl", 32'({io_rd, io_wr, ld_gnt, ram_we}), 32'(0));
    check_val("rl_acc", 32'(acc), 32'(0));
    check_val("rl_pc_rst", 32'(pc), 32'(RPC));
    tick(); #2;
    check_val("rel_load_gnt", 32'(ld_gnt), 32'(1));
    check_val("rel_load_pc", 32'(pc), 32'(RPC));
    ld_we = 1'b0; ld_en = 1'b0;
    tick();
    check_val("rel_exit_gnt", 32'(ld_gnt), 32'(0));
    m_pc = RPC; m_acc = 8'h00; m_zf = 1'b0; m_cf = 1'b0;
    run_instr(0, 8'h00);
    run_instr(1, 8'h3C);

    // Random programs against the reference model.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++)
        bd_write(8'(i), {ops[$urandom_range(0, 11)], 4'($urandom), 8'($urandom)});
      do_reset();
      for (int n = 0; n < 150; n++)
        run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
